// File: rtl/issue_stage_if.sv
// Shared uop type and the issue-to-ALU channel.
// Latency: none; pure type and wiring.
// Backpressure: none here; alu_stage stalls the issue stage through i_stall.
package issue_pkg;
  // alu_op is carried through untouched; rd/writes_rd drive hazard and scoreboard logic.
  typedef struct packed {
    logic [3:0] alu_op;
    logic       writes_rd;
    logic [4:0] rd;
  } uop_t;
endpackage

interface alu_issue_if #(parameter int XLEN = 32);
  import issue_pkg::*;
  logic            m_valid;
  uop_t            m_uop;
  logic [XLEN-1:0] m_op1;
  logic [XLEN-1:0] m_op2;
  modport issue (output m_valid, m_uop, m_op1, m_op2);
  modport alu   (input  m_valid, m_uop, m_op1, m_op2);
endinterface

// File: rtl/issue_stage.sv
// Single-entry issue stage: holds one uop, resolves operands, stalls on load scoreboard hits.
// Latency: one cycle from decode accept to m_valid; back-to-back issue with no bubble.
// Backpressure: o_dec_ready drops while the held uop is blocked by a hazard, i_stall or i_flush.
// Optional: define ISSUE_PERF_CNT_EN to add hazard and downstream stall counters.
module issue_stage
  import issue_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_dec_valid,
  output logic            o_dec_ready,
  input  uop_t            i_dec_uop,
  input  logic [4:0]      i_dec_rs1,
  input  logic [4:0]      i_dec_rs2,
  input  logic            i_dec_uses_rs1,
  input  logic            i_dec_uses_rs2,
  input  logic [XLEN-1:0] i_dec_imm,
  input  logic [XLEN-1:0] i_dec_pc,
  input  logic            i_dec_use_imm,
  input  logic            i_dec_use_pc,
  input  logic            i_dec_long,
  output logic [4:0]      o_rf_raddr1,
  output logic [4:0]      o_rf_raddr2,
  input  logic [XLEN-1:0] i_rf_rdata1,
  input  logic [XLEN-1:0] i_rf_rdata2,
  input  logic [4:0]      i_alu_fwd_rd,
  input  logic [XLEN-1:0] i_alu_fwd_result,
  input  logic            i_alu_fwd_writes_rd,
  input  logic            i_wb_valid,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  alu_issue_if.issue      issue_if,
  input  logic            i_stall,
  input  logic            i_flush
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]     o_stall_hazard_cnt,
  output logic [31:0]     o_stall_ds_cnt
`endif
);

  logic            hold_valid;
  uop_t            hold_uop;
  logic [4:0]      hold_rs1, hold_rs2;
  logic            hold_uses_rs1, hold_uses_rs2;
  logic [XLEN-1:0] hold_imm, hold_pc;
  logic            hold_use_imm, hold_use_pc, hold_long;
  logic [NREG-1:0] sb, sb_next;

  logic raw1, raw2, waw, hazard, m_valid, fire, accept;
  logic [XLEN-1:0] rs1_val, rs2_val;

  // A writeback landing this cycle satisfies a RAW wait (its data is forwarded), but not a WAW.
  always_comb begin
    raw1   = hold_uses_rs1 && (hold_rs1 != 5'd0) && sb[hold_rs1] &&
             !(i_wb_valid && (i_wb_rd == hold_rs1));
    raw2   = hold_uses_rs2 && (hold_rs2 != 5'd0) && sb[hold_rs2] &&
             !(i_wb_valid && (i_wb_rd == hold_rs2));
    waw    = hold_long && hold_uop.writes_rd && (hold_uop.rd != 5'd0) && sb[hold_uop.rd];
    hazard = hold_valid && (raw1 || raw2 || waw);
    m_valid     = hold_valid && !hazard && !i_flush;
    fire        = m_valid && !i_stall;
    o_dec_ready = !hold_valid || fire;
    accept      = i_dec_valid && o_dec_ready;
  end

  // Youngest producer wins: ALU stage, then writeback, then architectural register file.
  function automatic logic [XLEN-1:0] resolve(input logic [4:0] idx, input logic [XLEN-1:0] rf_data);
    if (idx == 5'd0) return '0;
    if (i_alu_fwd_writes_rd && (i_alu_fwd_rd == idx)) return i_alu_fwd_result;
    if (i_wb_valid && (i_wb_rd == idx)) return i_wb_data;
    return rf_data;
  endfunction

  assign o_rf_raddr1 = hold_rs1;
  assign o_rf_raddr2 = hold_rs2;

  // Operand muxing; bubbles present an all-zero uop so forwarding downstream never matches.
  always_comb begin
    rs1_val          = resolve(hold_rs1, i_rf_rdata1);
    rs2_val          = resolve(hold_rs2, i_rf_rdata2);
    issue_if.m_valid = m_valid;
    issue_if.m_uop   = m_valid ? hold_uop : '0;
    issue_if.m_op1   = hold_use_pc  ? hold_pc  : rs1_val;
    issue_if.m_op2   = hold_use_imm ? hold_imm : rs2_val;
  end

  // Scoreboard update: writeback clears, a firing load sets; set applied last so it wins.
  always_comb begin
    sb_next = sb;
    if (i_wb_valid) sb_next[i_wb_rd] = 1'b0;
    if (fire && hold_long && hold_uop.writes_rd && (hold_uop.rd != 5'd0))
      sb_next[hold_uop.rd] = 1'b1;
    sb_next[0] = 1'b0;
  end

  // Hold register: flush drops the entry (and any same-cycle accept), otherwise load or drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid    <= 1'b0;
      hold_uop      <= '0;
      hold_rs1      <= '0;
      hold_rs2      <= '0;
      hold_uses_rs1 <= 1'b0;
      hold_uses_rs2 <= 1'b0;
      hold_imm      <= '0;
      hold_pc       <= '0;
      hold_use_imm  <= 1'b0;
      hold_use_pc   <= 1'b0;
      hold_long     <= 1'b0;
    end else if (i_flush) begin
      hold_valid <= 1'b0;
    end else if (accept) begin
      hold_valid    <= 1'b1;
      hold_uop      <= i_dec_uop;
      hold_rs1      <= i_dec_rs1;
      hold_rs2      <= i_dec_rs2;
      hold_uses_rs1 <= i_dec_uses_rs1;
      hold_uses_rs2 <= i_dec_uses_rs2;
      hold_imm      <= i_dec_imm;
      hold_pc       <= i_dec_pc;
      hold_use_imm  <= i_dec_use_imm;
      hold_use_pc   <= i_dec_use_pc;
      hold_long     <= i_dec_long;
    end else if (fire) begin
      hold_valid <= 1'b0;
    end
  end

  // Scoreboard register; survives flush because older loads are still in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sb <= '0;
    else        sb <= sb_next;
  end

`ifdef ISSUE_PERF_CNT_EN
  // Stall counters: cycles lost to operand hazards and to downstream backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_stall_hazard_cnt <= '0;
      o_stall_ds_cnt     <= '0;
    end else begin
      if (hazard && !i_flush) o_stall_hazard_cnt <= o_stall_hazard_cnt + 32'd1;
      if (m_valid && i_stall) o_stall_ds_cnt     <= o_stall_ds_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_issue_stage.sv
// Directed bench for issue_stage: hand-computed vectors checked with immediate assertions.
// Inputs change 1 time unit after the rising edge; outputs are checked on the falling edge.
// Register file model returns 0x100+idx for every nonzero index.
module tb_issue_stage;
  import issue_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dec_valid, dec_ready;
  uop_t        dec_uop;
  logic [4:0]  dec_rs1, dec_rs2;
  logic        dec_uses_rs1, dec_uses_rs2;
  logic [31:0] dec_imm, dec_pc;
  logic        dec_use_imm, dec_use_pc, dec_long;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic [4:0]  alu_fwd_rd;
  logic [31:0] alu_fwd_result;
  logic        alu_fwd_writes_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        stall, flush;
`ifdef ISSUE_PERF_CNT_EN
  logic [31:0] hz_cnt, ds_cnt;
`endif

  logic [31:0] rf [32];
  int n_cmp = 0;
  int n_bad = 0;

  alu_issue_if #(.XLEN(32)) aif ();

  issue_stage #(.XLEN(32), .NREG(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_dec_valid(dec_valid), .o_dec_ready(dec_ready), .i_dec_uop(dec_uop),
    .i_dec_rs1(dec_rs1), .i_dec_rs2(dec_rs2),
    .i_dec_uses_rs1(dec_uses_rs1), .i_dec_uses_rs2(dec_uses_rs2),
    .i_dec_imm(dec_imm), .i_dec_pc(dec_pc),
    .i_dec_use_imm(dec_use_imm), .i_dec_use_pc(dec_use_pc), .i_dec_long(dec_long),
    .o_rf_raddr1(rf_raddr1), .o_rf_raddr2(rf_raddr2),
    .i_rf_rdata1(rf_rdata1), .i_rf_rdata2(rf_rdata2),
    .i_alu_fwd_rd(alu_fwd_rd), .i_alu_fwd_result(alu_fwd_result),
    .i_alu_fwd_writes_rd(alu_fwd_writes_rd),
    .i_wb_valid(wb_valid), .i_wb_rd(wb_rd), .i_wb_data(wb_data),
    .issue_if(aif),
    .i_stall(stall), .i_flush(flush)
`ifdef ISSUE_PERF_CNT_EN
    , .o_stall_hazard_cnt(hz_cnt), .o_stall_ds_cnt(ds_cnt)
`endif
  );

  always #5 clk = ~clk;

  assign rf_rdata1 = rf[rf_raddr1];
  assign rf_rdata2 = rf[rf_raddr2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  function automatic uop_t mk(input logic [4:0] rd, input logic wr);
    uop_t u;
    u.alu_op    = 4'd0;
    u.writes_rd = wr;
    u.rd        = rd;
    return u;
  endfunction

  task automatic drv(input logic v, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic [31:0] imm, input logic uimm,
                     input logic [31:0] pc, input logic upc, input logic lng);
    dec_valid    = v;
    dec_uop      = mk(rd, 1'b1);
    dec_rs1      = rs1;
    dec_rs2      = rs2;
    dec_uses_rs1 = u1;
    dec_uses_rs2 = u2;
    dec_imm      = imm;
    dec_use_imm  = uimm;
    dec_pc       = pc;
    dec_use_pc   = upc;
    dec_long     = lng;
  endtask

  task automatic wb(input logic v, input logic [4:0] rd, input logic [31:0] d);
    wb_valid = v;
    wb_rd    = rd;
    wb_data  = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = (i == 0) ? 32'd0 : 32'h100 + i;
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    wb(0, 0, 0);
    alu_fwd_rd = 0; alu_fwd_result = 0; alu_fwd_writes_rd = 0;
    stall = 0; flush = 0;

    // Reset state
    mid();
    chk("rst_ready", dec_ready, 1);
    chk("rst_mvalid", aif.m_valid, 0);
    chk("rst_muop", aif.m_uop, 0);
    chk("rst_sb", dut.sb, 0);
    tick();
    rst_n = 1'b1;

    // Back-to-back independent: ADD x1,x2,x3 then ADD x4,x5,x6
    drv(1, 1, 2, 3, 1, 1, 0, 0, 0, 0, 0);
    mid(); chk("b2b_ready0", dec_ready, 1);
    tick();
    drv(1, 4, 5, 6, 1, 1, 0, 0, 0, 0, 0);
    mid();
    chk("b2b_v1", aif.m_valid, 1);
    chk("b2b_uop1", aif.m_uop, mk(1, 1));
    chk("b2b_op1a", aif.m_op1, 32'h102);
    chk("b2b_op2a", aif.m_op2, 32'h103);
    chk("b2b_ready1", dec_ready, 1);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mid();
    chk("b2b_v2", aif.m_valid, 1);
    chk("b2b_uop2", aif.m_uop, mk(4, 1));
    chk("b2b_op1b", aif.m_op1, 32'h105);
    chk("b2b_op2b", aif.m_op2, 32'h106);
    chk("b2b_ready2", dec_ready, 1);
    tick();
    mid();
    chk("b2b_idle_v", aif.m_valid, 0);
    chk("b2b_idle_uop", aif.m_uop, 0);

    // ALU forward: ADDI x1,x0,5 then ADD x2,x1,x1; ALU forward outranks writeback
    drv(1, 1, 0, 0, 1, 0, 5, 1, 0, 0, 0);
    tick();
    drv(1, 2, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    mid();
    chk("addi_op1", aif.m_op1, 0);
    chk("addi_op2", aif.m_op2, 5);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    alu_fwd_rd = 1; alu_fwd_result = 5; alu_fwd_writes_rd = 1;
    wb(1, 1, 32'h77);
    mid();
    chk("fwd_v", aif.m_valid, 1);
    chk("fwd_op1", aif.m_op1, 5);
    chk("fwd_op2", aif.m_op2, 5);
    tick();
    alu_fwd_rd = 0; alu_fwd_result = 0; alu_fwd_writes_rd = 0;
    wb(0, 0, 0);

    // Load-use: LW x3 then ADD x4,x3,x0 waits for writeback of x3
    drv(1, 3, 2, 0, 1, 0, 4, 1, 0, 0, 1);
    tick();
    drv(1, 4, 3, 0, 1, 1, 0, 0, 0, 0, 0);
    mid(); chk("lw_v", aif.m_valid, 1);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mid();
    chk("lu_sb", dut.sb, 32'h8);
    chk("lu_v1", aif.m_valid, 0);
    chk("lu_ready1", dec_ready, 0);
    tick();
    mid();
    chk("lu_v2", aif.m_valid, 0);
    chk("lu_ready2", dec_ready, 0);
    tick();
    wb(1, 3, 32'hAB);
    mid();
    chk("lu_wb_v", aif.m_valid, 1);
    chk("lu_wb_uop", aif.m_uop, mk(4, 1));
    chk("lu_wb_op1", aif.m_op1, 32'hAB);
    chk("lu_wb_op2", aif.m_op2, 0);
    chk("lu_wb_ready", dec_ready, 1);
    tick();
    wb(0, 0, 0);
    mid();
    chk("lu_sb_clr", dut.sb, 0);
    chk("lu_done_v", aif.m_valid, 0);

    // Flush with a load in flight; same-cycle set/clear of sb[5] keeps the set
    drv(1, 5, 2, 0, 1, 0, 8, 1, 0, 0, 1);
    tick();
    drv(1, 6, 7, 8, 1, 1, 0, 0, 0, 0, 0);
    wb(1, 5, 32'h55);
    mid(); chk("fl_lw_v", aif.m_valid, 1);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    wb(0, 0, 0);
    flush = 1;
    mid();
    chk("fl_sb_setwins", dut.sb, 32'h20);
    chk("fl_v", aif.m_valid, 0);
    chk("fl_uop", aif.m_uop, 0);
    chk("fl_ready", dec_ready, 0);
    chk("fl_hold", dut.hold_valid, 1);
    tick();
    flush = 0;
    mid();
    chk("fl_hold_next", dut.hold_valid, 0);
    chk("fl_v_next", aif.m_valid, 0);
    chk("fl_ready_next", dec_ready, 1);
    chk("fl_sb_kept", dut.sb, 32'h20);
    tick();
    // Accept during a flush on an empty stage is dropped
    drv(1, 6, 7, 8, 1, 1, 0, 0, 0, 0, 0);
    flush = 1;
    mid(); chk("fl_acc_ready", dec_ready, 1);
    tick();
    flush = 0;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mid();
    chk("fl_acc_drop", dut.hold_valid, 0);
    chk("fl_acc_v", aif.m_valid, 0);

    // Downstream stall for three cycles, then a PC+imm uop follows with no bubble
    stall = 1;
    drv(1, 9, 10, 11, 1, 1, 0, 0, 0, 0, 0);
    tick();
    drv(1, 12, 0, 0, 0, 0, 32'h20, 1, 32'h1000, 1, 0);
    for (int c = 0; c < 3; c++) begin
      mid();
      chk("st_v", aif.m_valid, 1);
      chk("st_uop", aif.m_uop, mk(9, 1));
      chk("st_op1", aif.m_op1, 32'h10A);
      chk("st_op2", aif.m_op2, 32'h10B);
      chk("st_ready", dec_ready, 0);
      tick();
    end
    stall = 0;
    mid();
    chk("st_rel_v", aif.m_valid, 1);
    chk("st_rel_uop", aif.m_uop, mk(9, 1));
    chk("st_rel_ready", dec_ready, 1);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mid();
    chk("pc_uop", aif.m_uop, mk(12, 1));
    chk("pc_op1", aif.m_op1, 32'h1000);
    chk("pc_op2", aif.m_op2, 32'h20);
    tick();

    // WAW: second load to x5 waits until sb[5] is actually clear (no writeback bypass)
    drv(1, 5, 2, 0, 1, 0, 8, 1, 0, 0, 1);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    wb(1, 5, 32'h66);
    mid();
    chk("waw_v", aif.m_valid, 0);
    chk("waw_ready", dec_ready, 0);
    tick();
    wb(0, 0, 0);
    mid();
    chk("waw_sb_clr", dut.sb, 0);
    chk("waw_go", aif.m_valid, 1);
    tick();
    mid(); chk("waw_sb_set", dut.sb, 32'h20);
    tick();
    wb(1, 5, 32'h66);
    tick();
    wb(0, 0, 0);
    mid(); chk("waw_sb_done", dut.sb, 0);
    tick();

    // Reset mid-op: sb[3] set and a dependent uop held
    drv(1, 3, 2, 0, 1, 0, 4, 1, 0, 0, 1);
    tick();
    drv(1, 4, 3, 0, 1, 1, 0, 0, 0, 0, 0);
    tick();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mid();
    chk("mr_sb_pre", dut.sb, 32'h8);
    chk("mr_hold_pre", dut.hold_valid, 1);
    chk("mr_v_pre", aif.m_valid, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mr_v", aif.m_valid, 0);
    chk("mr_sb", dut.sb, 0);
    chk("mr_ready", dec_ready, 1);
    chk("mr_hold", dut.hold_valid, 0);
    tick();
    rst_n = 1'b1;
    mid();
    chk("mr_after_v", aif.m_valid, 0);
    chk("mr_after_ready", dec_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/issue_stage.md
Name: issue_stage

Overview:
- Single-entry issue stage between decode and alu_stage.
- Accepts decoded uops from decode with a valid/ready handshake and holds one uop.
- Resolves source operands from the register file, ALU-stage forwarding and writeback forwarding.
- Tracks long-latency destination registers (loads) in a 32-bit scoreboard, stalls dependent uops, and drives alu_stage through the alu_issue_if issue-side modport.

Parameters:
- XLEN, 32, operand/result width.
- NREG, 32, architectural register count; scoreboard width.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- i_dec_valid  input  1  decode has a uop
- o_dec_ready  output  1  stage can accept a uop this cycle
- i_dec_uop  input  uop_t  decoded uop (rd, writes_rd, alu_op used here)
- i_dec_rs1 / i_dec_rs2  input  5 each  source indices
- i_dec_uses_rs1 / i_dec_uses_rs2  input  1 each  source actually read
- i_dec_imm  input  32  immediate
- i_dec_pc  input  32  uop PC
- i_dec_use_imm / i_dec_use_pc  input  1 each  op2=imm / op1=pc select
- i_dec_long  input  1  result returns later via writeback (load)
- o_rf_raddr1 / o_rf_raddr2  output  5 each  register file read addresses (combinational)
- i_rf_rdata1 / i_rf_rdata2  input  32 each  register file read data (combinational)
- i_alu_fwd_rd  input  5  ALU-stage destination
- i_alu_fwd_result  input  32  ALU-stage result
- i_alu_fwd_writes_rd  input  1  ALU-stage writes rd
- i_wb_valid  input  1  writeback commits this cycle
- i_wb_rd  input  5  writeback destination
- i_wb_data  input  32  writeback data
- issue_if  modport  alu_issue_if.issue  drives m_valid, m_uop, m_op1, m_op2
- i_stall  input  1  downstream stall
- i_flush  input  1  branch/exception flush

Behaviour:
- Reset (async, rst_n=0):
  - hold_valid=0; hold registers=0; scoreboard=0.
  - Outputs after reset: o_dec_ready=1, m_valid=0, m_uop='0.
- hazard: hold_valid AND any of the following:
  - uses_rs1 & rs1!=0 & sb[rs1] & !(i_wb_valid & i_wb_rd==rs1)
  - same condition for rs2
  - hold_long & writes_rd & rd!=0 & sb[rd] (WAW)
- m_valid = hold_valid & !hazard & !i_flush.
- fire = m_valid & !i_stall. alu_stage samples issue_if in the same cycle.
- m_uop = hold_uop when m_valid, else '0. This keeps bubbles inert for forwarding.
- o_dec_ready = !hold_valid | fire. Accept = i_dec_valid & o_dec_ready; the hold register loads on the next clock edge.
- Fire and accept in the same cycle: zero-bubble back-to-back issue.
- Hold register keeps its contents while hazard or i_stall is asserted.
- Flush:
  - hold_valid<=0 on the next edge; o_dec_ready is still driven by the formula above; an accept in a flush cycle is discarded.
  - Scoreboard is not cleared (older long ops are still in flight).
- Operand resolution, per source, in priority order:
  1. idx==0 -> 0
  2. i_alu_fwd_writes_rd & i_alu_fwd_rd==idx -> i_alu_fwd_result
  3. i_wb_valid & i_wb_rd==idx -> i_wb_data
  4. otherwise register file data
- m_op1 = use_pc ? pc : rs1val. m_op2 = use_imm ? imm : rs2val.
- Scoreboard:
  - Fire of a long uop with writes_rd & rd!=0 sets sb[rd].
  - i_wb_valid clears sb[i_wb_rd].
  - Set and clear of the same index in one cycle: set wins.
  - sb[0] is never set.
- Latency: decode accept to m_valid = 1 cycle minimum. Issue adds no latency beyond the hold register.

Optional Feature:
- ISSUE_PERF_CNT_EN: adds o_stall_hazard_cnt (32) and o_stall_ds_cnt (32).
  - Both reset to 0 and wrap at 2^32.
  - o_stall_hazard_cnt increments each cycle hold_valid & hazard & !i_flush.
  - o_stall_ds_cnt increments each cycle m_valid & i_stall.
- Without the macro: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Back-to-back independent: decode ADD x1,x2,x3 then ADD x4,x5,x6 with i_stall=0 -> m_valid high two consecutive cycles, o_dec_ready stays 1.
- ALU forward: issue ADDI x1,x0,5 (result 5), next ADD x2,x1,x1 -> m_op1=m_op2=5 from ALU forward, not the stale regfile value 0.
- Load-use: issue long LW x3 (sb[3]=1), then ADD x4,x3,x0 -> m_valid=0 and o_dec_ready=0 until i_wb_valid,i_wb_rd=3,i_wb_data=0xAB. ADD issues that same cycle with m_op1=0xAB; sb[3]=0 next cycle.
- Downstream stall: hold a uop with i_stall=1 for 3 cycles -> m_valid=1 held, m_uop/ops stable, o_dec_ready=0; releases on the cycle i_stall falls.
- Flush: hold a valid uop and assert i_flush -> m_valid=0 that cycle, hold_valid=0 next cycle, sb bits for in-flight loads unchanged.
- Reset mid-op: rst_n low with sb=0x0000_0008 and hold_valid=1 -> immediately m_valid=0, sb=0, o_dec_ready=1.
